// File: rtl/ifu_fetch_pkg.sv
// Shared core definitions for the instruction fetch unit: FSM encoding,
// reset fetch address and the redirect-target alignment helper.
package ifu_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        DRAIN = 2'b01,
        VALID = 2'b10
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    // Instructions are word aligned; low address bits of a target are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-cache request/response plus the
// decode handshake and the execute redirect.
interface ifu_fetch_if;
    logic        rreq_o;
    logic [31:0] raddr_o;
    logic        rready_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_ready_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;

    modport master (
        output rreq_o, raddr_o, inst_valid_o, inst_o, pc_o,
        input  rready_i, rvalid_i, rdata_i, inst_ready_i,
               redirect_valid_i, redirect_pc_i
    );

    modport slave (
        input  rreq_o, raddr_o, inst_valid_o, inst_o, pc_o,
        output rready_i, rvalid_i, rdata_i, inst_ready_i,
               redirect_valid_i, redirect_pc_i
    );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: requests one word from the
// I-cache, holds it for decode, and drains in-flight misses on redirect.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic         clock,
    input  logic         reset,
    ifu_fetch_if.master  bus
);

    ifu_state_e  state_r;
    logic [31:0] pc_r;
    logic [31:0] pending_pc_r;
    logic [31:0] inst_r;
    logic [31:0] pc_out_r;
    logic        rreq_r;
    logic        inst_valid_r;
    logic [31:0] target_s;
    logic        unused_rready_s;

    assign target_s        = align_pc(bus.redirect_pc_i);
    assign unused_rready_s = bus.rready_i;

    // Fetch FSM; pc_r is never changed while a miss is outstanding so the
    // cache always sees a stable miss address, even while draining.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            pending_pc_r <= 32'h0000_0000;
            inst_r       <= 32'h0000_0000;
            pc_out_r     <= 32'h0000_0000;
            rreq_r       <= 1'b1;
            inst_valid_r <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (bus.redirect_valid_i) begin
                        if (bus.rvalid_i) begin
                            pc_r <= target_s;
                        end else begin
                            pending_pc_r <= target_s;
                            state_r      <= DRAIN;
                            rreq_r       <= 1'b0;
                        end
                    end else if (bus.rvalid_i) begin
                        inst_r       <= bus.rdata_i;
                        pc_out_r     <= pc_r;
                        state_r      <= VALID;
                        rreq_r       <= 1'b0;
                        inst_valid_r <= 1'b1;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                DRAIN: begin
                    // The late response is discarded; a same-cycle redirect beats pending_pc_r.
                    if (bus.rvalid_i) begin
                        pc_r    <= bus.redirect_valid_i ? target_s : pending_pc_r;
                        state_r <= FETCH;
                        rreq_r  <= 1'b1;
                    end else if (bus.redirect_valid_i) begin
                        pending_pc_r <= target_s;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                VALID: begin
                    if (bus.redirect_valid_i) begin
                        pc_r         <= target_s;
                        state_r      <= FETCH;
                        rreq_r       <= 1'b1;
                        inst_valid_r <= 1'b0;
                    end else if (bus.inst_ready_i) begin
                        pc_r         <= pc_r + 32'd4;
                        state_r      <= FETCH;
                        rreq_r       <= 1'b1;
                        inst_valid_r <= 1'b0;
                    end else begin
                        state_r <= VALID;
                    end
                end
                default: begin
                    state_r      <= FETCH;
                    rreq_r       <= 1'b1;
                    inst_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rreq_o       = rreq_r;
    assign bus.raddr_o      = pc_r;
    assign bus.inst_valid_o = inst_valid_r;
    assign bus.inst_o       = inst_r;
    assign bus.pc_o         = pc_out_r;

endmodule
